// File: rtl/cby_param_cb.sv
// Parametrised Y-channel connection block: track pass-through, per-pin muxes and a
// frame-load controller with a shadow register. Optional macro CB_CFG_PARITY_EN adds even parity and cfg_err.
module cby_param_cb #(
   parameter int CHAN_W   = 9,
   parameter int NUM_PINS = 5,
   parameter int MUX_SIZE = 6,
   parameter int STRIDE   = 4
) (
   input  logic                prog_clk,
   input  logic                pReset_n,
   input  logic                ccff_head,
   input  logic                ccff_shift_en,
   input  logic [CHAN_W-1:0]   chany_bottom_in,
   input  logic [CHAN_W-1:0]   chany_top_in,
   output logic [CHAN_W-1:0]   chany_bottom_out,
   output logic [CHAN_W-1:0]   chany_top_out,
   output logic [NUM_PINS-1:0] grid_pin,
   output logic                ccff_tail,
`ifdef CB_CFG_PARITY_EN
   output logic                cfg_err,
`endif
   output logic                cfg_done
);

   localparam int SEL_W     = $clog2(MUX_SIZE);
   localparam int CFG_BITS  = NUM_PINS * SEL_W;
`ifdef CB_CFG_PARITY_EN
   localparam int CHAIN_LEN = CFG_BITS + 1;
`else
   localparam int CHAIN_LEN = CFG_BITS;
`endif
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam int PAD_SIZE  = 1 << SEL_W;

   typedef enum logic [1:0] {
      ST_UNCONFIG,
      ST_LOADING,
      ST_COMMIT,
      ST_CONFIGURED
   } state_t;

   // A one-bit chain completes its frame on the very first shift.
   localparam state_t           START_ST  = (CHAIN_LEN == 1) ? ST_COMMIT : ST_LOADING;
   localparam logic [CNT_W-1:0] START_CNT = (CHAIN_LEN == 1) ? '0 : CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CHAIN_LEN - 1);

   state_t               state_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [CHAIN_LEN-1:0] sr_reg;
   logic [CFG_BITS-1:0]  shadow_reg;
   logic                 valid_reg;
   logic                 cfg_done_reg;
`ifdef CB_CFG_PARITY_EN
   logic                 cfg_err_reg;
`endif

   always_ff @(posedge prog_clk) begin
      if (!pReset_n) begin
         state_reg    <= ST_UNCONFIG;
         cnt_reg      <= '0;
         sr_reg       <= '0;
         shadow_reg   <= '0;
         valid_reg    <= 1'b0;
         cfg_done_reg <= 1'b0;
`ifdef CB_CFG_PARITY_EN
         cfg_err_reg  <= 1'b0;
`endif
      end else begin
         if (ccff_shift_en) begin
            sr_reg <= (sr_reg << 1) | CHAIN_LEN'(ccff_head);
         end
         case (state_reg)
            ST_UNCONFIG, ST_CONFIGURED: begin
               if (ccff_shift_en) begin
                  state_reg    <= START_ST;
                  cnt_reg      <= START_CNT;
                  cfg_done_reg <= 1'b0;
               end
            end
            ST_LOADING: begin
               if (ccff_shift_en) begin
                  if (cnt_reg == LAST_CNT) begin
                     state_reg <= ST_COMMIT;
                     cnt_reg   <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + CNT_W'(1);
                  end
               end
            end
            ST_COMMIT: begin
               // sr_reg here is still the completed frame; a shift this cycle only affects the next one.
`ifdef CB_CFG_PARITY_EN
               if (^sr_reg) begin
                  cfg_err_reg  <= 1'b1;
                  cfg_done_reg <= 1'b0;
               end else begin
                  shadow_reg   <= sr_reg[CFG_BITS-1:0];
                  valid_reg    <= 1'b1;
                  cfg_done_reg <= 1'b1;
                  cfg_err_reg  <= 1'b0;
               end
`else
               shadow_reg   <= sr_reg[CFG_BITS-1:0];
               valid_reg    <= 1'b1;
               cfg_done_reg <= 1'b1;
`endif
               if (ccff_shift_en) begin
                  state_reg <= START_ST;
                  cnt_reg   <= START_CNT;
               end else begin
                  state_reg <= ST_CONFIGURED;
               end
            end
            default: state_reg <= ST_UNCONFIG;
         endcase
      end
   end

   assign chany_bottom_out = chany_top_in;
   assign chany_top_out    = chany_bottom_in;
   assign ccff_tail        = sr_reg[CHAIN_LEN-1];
   assign cfg_done         = cfg_done_reg;
`ifdef CB_CFG_PARITY_EN
   assign cfg_err          = cfg_err_reg;
`endif

   genvar gi, gj;
   generate
      for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
         logic [PAD_SIZE-1:0] mux_in;
         logic [SEL_W-1:0]    sel;

         assign sel = shadow_reg[gi*SEL_W +: SEL_W];

         // Inputs beyond MUX_SIZE are tied low so out-of-range selects read 0.
         for (gj = 0; gj < PAD_SIZE; gj++) begin : g_in
            if (gj < MUX_SIZE) begin : g_track
               localparam int TRACK = (gi + (gj / 2) * STRIDE) % CHAN_W;
               assign mux_in[gj] = (gj % 2 == 0) ? chany_bottom_in[TRACK] : chany_top_in[TRACK];
            end else begin : g_pad
               assign mux_in[gj] = 1'b0;
            end
         end

         assign grid_pin[gi] = valid_reg & mux_in[sel];
      end
   endgenerate

endmodule

// File: tb/tb_cby_param_cb.sv
// Self-checking bench for cby_param_cb: directed scenarios plus a randomized run
// against a frame-level reference model.
module tb_cby_param_cb;

   localparam int CHAN_W   = 9;
   localparam int NUM_PINS = 5;
   localparam int MUX_SIZE = 6;
   localparam int STRIDE   = 4;
   localparam int SEL_W    = $clog2(MUX_SIZE);
   localparam int CFG_BITS = NUM_PINS * SEL_W;
`ifdef CB_CFG_PARITY_EN
   localparam int CHAIN    = CFG_BITS + 1;
`else
   localparam int CHAIN    = CFG_BITS;
`endif

   logic                prog_clk;
   logic                pReset_n;
   logic                ccff_head;
   logic                ccff_shift_en;
   logic [CHAN_W-1:0]   chany_bottom_in;
   logic [CHAN_W-1:0]   chany_top_in;
   logic [CHAN_W-1:0]   chany_bottom_out;
   logic [CHAN_W-1:0]   chany_top_out;
   logic [NUM_PINS-1:0] grid_pin;
   logic                ccff_tail;
   logic                cfg_done;
`ifdef CB_CFG_PARITY_EN
   logic                cfg_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   cby_param_cb #(
      .CHAN_W  (CHAN_W),
      .NUM_PINS(NUM_PINS),
      .MUX_SIZE(MUX_SIZE),
      .STRIDE  (STRIDE)
   ) dut (
      .prog_clk        (prog_clk),
      .pReset_n        (pReset_n),
      .ccff_head       (ccff_head),
      .ccff_shift_en   (ccff_shift_en),
      .chany_bottom_in (chany_bottom_in),
      .chany_top_in    (chany_top_in),
      .chany_bottom_out(chany_bottom_out),
      .chany_top_out   (chany_top_out),
      .grid_pin        (grid_pin),
      .ccff_tail       (ccff_tail),
`ifdef CB_CFG_PARITY_EN
      .cfg_err         (cfg_err),
`endif
      .cfg_done        (cfg_done)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   // Reference model: chain contents, bits received in the current frame,
   // a pending-commit flag and the committed select values per pin.
   logic [CHAIN-1:0] m_sr;
   int               m_sel [NUM_PINS];
   bit               m_valid;
   bit               m_done;
   bit               m_commit;
   int               m_bits;
`ifdef CB_CFG_PARITY_EN
   bit               m_err;
`endif

   task automatic model_edge(input bit rst_n, input bit sh, input bit head);
      logic [CFG_BITS-1:0] fld;
      bit ok;
      if (!rst_n) begin
         m_sr = '0; m_valid = 0; m_done = 0; m_commit = 0; m_bits = 0;
`ifdef CB_CFG_PARITY_EN
         m_err = 0;
`endif
         for (int p = 0; p < NUM_PINS; p++) m_sel[p] = 0;
         return;
      end
      if (m_commit) begin
         fld = m_sr[CFG_BITS-1:0];
         ok  = 1;
`ifdef CB_CFG_PARITY_EN
         ok  = ((^m_sr) == 1'b0);
`endif
         if (ok) begin
            for (int p = 0; p < NUM_PINS; p++) m_sel[p] = int'(fld[p*SEL_W +: SEL_W]);
            m_valid = 1;
            m_done  = 1;
`ifdef CB_CFG_PARITY_EN
            m_err   = 0;
`endif
         end else begin
`ifdef CB_CFG_PARITY_EN
            m_err   = 1;
`endif
            m_done  = 0;
         end
         m_commit = 0;
         m_bits   = sh ? 1 : 0;
      end else if (sh) begin
         if (m_bits == 0) m_done = 0;
         m_bits++;
      end
      if (m_bits == CHAIN) begin
         m_commit = 1;
         m_bits   = 0;
      end
      if (sh) m_sr = {m_sr[CHAIN-2:0], head};
   endtask

   function automatic logic [NUM_PINS-1:0] exp_pins();
      logic [NUM_PINS-1:0] r;
      int t;
      r = '0;
      for (int p = 0; p < NUM_PINS; p++) begin
         if (m_valid && m_sel[p] < MUX_SIZE) begin
            t    = (p + (m_sel[p] / 2) * STRIDE) % CHAN_W;
            r[p] = (m_sel[p] % 2 == 1) ? chany_top_in[t] : chany_bottom_in[t];
         end
      end
      return r;
   endfunction

   function automatic logic [CHAIN-1:0] make_frame(input logic [CFG_BITS-1:0] fields, input bit bad_par);
      logic [CHAIN-1:0] f;
`ifdef CB_CFG_PARITY_EN
      f = {(^fields) ^ bad_par, fields};
`else
      f = fields ^ CHAIN'(bad_par & 1'b0);
`endif
      return f;
   endfunction

   // One prog_clk cycle: drive at the falling edge, update the model at the rising edge, sample 1 ns later.
   task automatic tick(input bit rst_n, input bit sh, input bit head);
      @(negedge prog_clk);
      pReset_n        = rst_n;
      ccff_shift_en   = sh;
      ccff_head       = head;
      chany_bottom_in = CHAN_W'($urandom);
      chany_top_in    = CHAN_W'($urandom);
      @(posedge prog_clk);
      model_edge(rst_n, sh, head);
      #1;
   endtask

   task automatic shift_frame(input logic [CHAIN-1:0] f);
      $display("[TB] shift frame %h", f);
      for (int i = CHAIN - 1; i >= 0; i--) tick(1, 1, f[i]);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         tick(0, 1, 1);
         n_tests++; if (grid_pin !== '0) begin n_fail++; $display("FAIL reset_grid_pin got=%b exp=0", grid_pin); end
         n_tests++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_done got=%b exp=0", cfg_done); end
         n_tests++; if (ccff_tail !== 1'b0) begin n_fail++; $display("FAIL reset_ccff_tail got=%b exp=0", ccff_tail); end
         n_tests++; if (chany_top_out !== chany_bottom_in) begin n_fail++; $display("FAIL reset_top_out got=%h exp=%h", chany_top_out, chany_bottom_in); end
         n_tests++; if (chany_bottom_out !== chany_top_in) begin n_fail++; $display("FAIL reset_bottom_out got=%h exp=%h", chany_bottom_out, chany_top_in); end
      end
      $display("[TB] reset held for 2 edges");
   endtask

   task automatic test_sel5();
      logic [CFG_BITS-1:0] fields;
      logic [CHAIN-1:0]    f;
      fields = '0;
      fields[SEL_W-1:0] = SEL_W'(5);
      f = make_frame(fields, 0);
      shift_frame(f);
      n_tests++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL sel5_done_early got=%b exp=0", cfg_done); end
      n_tests++; if (ccff_tail !== f[CHAIN-1]) begin n_fail++; $display("FAIL sel5_tail got=%b exp=%b", ccff_tail, f[CHAIN-1]); end
      tick(1, 0, 0);
      n_tests++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL sel5_done got=%b exp=1", cfg_done); end
      n_tests++; if (grid_pin !== exp_pins()) begin n_fail++; $display("FAIL sel5_pins got=%b exp=%b", grid_pin, exp_pins()); end
      for (int k = 0; k < 3; k++) begin
         chany_top_in[8] = ~chany_top_in[8];
         #1;
         n_tests++; if (grid_pin[0] !== chany_top_in[8]) begin n_fail++; $display("FAIL sel5_follow_top8 got=%b exp=%b", grid_pin[0], chany_top_in[8]); end
      end
      $display("[TB] sel[0]=5 committed, pin0 follows top8");
   endtask

   task automatic test_out_of_range();
      logic [CFG_BITS-1:0] fields;
      fields = CFG_BITS'($urandom);
      fields[SEL_W-1:0] = SEL_W'(7);
      shift_frame(make_frame(fields, 0));
      tick(1, 0, 0);
      n_tests++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL oor_done got=%b exp=1", cfg_done); end
      for (int c = 0; c < 8; c++) begin
         tick(1, 0, 0);
         n_tests++; if (grid_pin[0] !== 1'b0) begin n_fail++; $display("FAIL oor_pin0 got=%b exp=0", grid_pin[0]); end
         n_tests++; if (grid_pin !== exp_pins()) begin n_fail++; $display("FAIL oor_pins got=%b exp=%b", grid_pin, exp_pins()); end
      end
      $display("[TB] sel[0]=7 forces pin0 low");
   endtask

   task automatic test_reload_gaps();
      logic [CFG_BITS-1:0] fields;
      logic [CHAIN-1:0]    f;
      logic [31:0]         idle_mask;
      int total, nidle, pos, idx;
      fields = '0;
      fields[SEL_W-1:0] = SEL_W'(2);
      shift_frame(make_frame(fields, 0));
      tick(1, 0, 0);
      n_tests++; if (grid_pin[0] !== chany_bottom_in[4]) begin n_fail++; $display("FAIL reload_old_pin got=%b exp=%b", grid_pin[0], chany_bottom_in[4]); end
      fields[SEL_W-1:0] = SEL_W'(3);
      f = make_frame(fields, 0);
      total = CHAIN + 5;
      idle_mask = '0;
      nidle = 0;
      while (nidle < 5) begin
         pos = $urandom_range(total - 2, 1);
         if (!idle_mask[pos]) begin idle_mask[pos] = 1'b1; nidle++; end
      end
      idx = CHAIN - 1;
      for (int c = 0; c < total; c++) begin
         if (idle_mask[c]) tick(1, 0, 0);
         else begin tick(1, 1, f[idx]); idx--; end
         n_tests++; if (grid_pin[0] !== chany_bottom_in[4]) begin n_fail++; $display("FAIL reload_hold_pin cyc=%0d got=%b exp=%b", c, grid_pin[0], chany_bottom_in[4]); end
         n_tests++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reload_done_low cyc=%0d got=%b exp=0", c, cfg_done); end
      end
      tick(1, 0, 0);
      n_tests++; if (grid_pin[0] !== chany_top_in[4]) begin n_fail++; $display("FAIL reload_new_pin got=%b exp=%b", grid_pin[0], chany_top_in[4]); end
      n_tests++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL reload_done got=%b exp=1", cfg_done); end
      $display("[TB] reload with idle gaps, pin0 bot4 -> top4");
   endtask

   task automatic test_mid_reset();
      logic [CHAIN-1:0] f;
      for (int i = 0; i < 7; i++) tick(1, 1, 1'($urandom));
      tick(0, 0, 0);
      n_tests++; if (grid_pin !== '0) begin n_fail++; $display("FAIL midrst_pins got=%b exp=0", grid_pin); end
      n_tests++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", cfg_done); end
      n_tests++; if (ccff_tail !== 1'b0) begin n_fail++; $display("FAIL midrst_tail got=%b exp=0", ccff_tail); end
      f = make_frame(CFG_BITS'($urandom), 0);
      $display("[TB] shift frame %h after mid-frame reset", f);
      for (int i = CHAIN - 1; i >= 0; i--) begin
         tick(1, 1, f[i]);
         if (i > 0) begin
            n_tests++; if (ccff_tail !== 1'b0) begin n_fail++; $display("FAIL midrst_sr_clear shift=%0d got=%b exp=0", CHAIN - i, ccff_tail); end
         end
      end
      n_tests++; if (ccff_tail !== f[CHAIN-1]) begin n_fail++; $display("FAIL midrst_tail_full got=%b exp=%b", ccff_tail, f[CHAIN-1]); end
      tick(1, 0, 0);
      n_tests++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL midrst_commit_done got=%b exp=1", cfg_done); end
      n_tests++; if (grid_pin !== exp_pins()) begin n_fail++; $display("FAIL midrst_commit_pins got=%b exp=%b", grid_pin, exp_pins()); end
   endtask

   task automatic test_short_frame();
      tick(0, 0, 0);
      for (int i = 0; i < CHAIN - 1; i++) tick(1, 1, 1'($urandom));
      for (int c = 0; c < 10; c++) begin
         tick(1, 0, 0);
         n_tests++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL short_done cyc=%0d got=%b exp=0", c, cfg_done); end
         n_tests++; if (grid_pin !== '0) begin n_fail++; $display("FAIL short_pins cyc=%0d got=%b exp=0", c, grid_pin); end
      end
      $display("[TB] short frame of %0d bits left uncommitted", CHAIN - 1);
   endtask

`ifdef CB_CFG_PARITY_EN
   task automatic test_parity();
      logic [NUM_PINS-1:0] old_pins;
      logic [CFG_BITS-1:0] fields;
      shift_frame(make_frame(CFG_BITS'($urandom), 0));
      tick(1, 0, 0);
      n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL par_good_err got=%b exp=0", cfg_err); end
      fields = CFG_BITS'($urandom);
      shift_frame(make_frame(fields, 1));
      tick(1, 0, 0);
      n_tests++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_err got=%b exp=1", cfg_err); end
      n_tests++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL par_bad_done got=%b exp=0", cfg_done); end
      old_pins = exp_pins();
      n_tests++; if (grid_pin !== old_pins) begin n_fail++; $display("FAIL par_bad_pins_kept got=%b exp=%b", grid_pin, old_pins); end
      shift_frame(make_frame(fields, 0));
      tick(1, 0, 0);
      n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL par_fix_err got=%b exp=0", cfg_err); end
      n_tests++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL par_fix_done got=%b exp=1", cfg_done); end
      n_tests++; if (grid_pin !== exp_pins()) begin n_fail++; $display("FAIL par_fix_pins got=%b exp=%b", grid_pin, exp_pins()); end
   endtask
`endif

   task automatic test_random();
      bit rst_n, sh;
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(63) != 0);
         sh    = ($urandom_range(3) != 0);
         tick(rst_n, sh, 1'($urandom));
         n_tests++; if (grid_pin !== exp_pins()) begin n_fail++; $display("FAIL rand_pins cyc=%0d got=%b exp=%b", c, grid_pin, exp_pins()); end
         n_tests++; if (cfg_done !== m_done) begin n_fail++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", c, cfg_done, m_done); end
         n_tests++; if (ccff_tail !== m_sr[CHAIN-1]) begin n_fail++; $display("FAIL rand_tail cyc=%0d got=%b exp=%b", c, ccff_tail, m_sr[CHAIN-1]); end
         n_tests++; if (chany_top_out !== chany_bottom_in || chany_bottom_out !== chany_top_in) begin
            n_fail++; $display("FAIL rand_passthru cyc=%0d top_out=%h bot_out=%h exp %h %h", c, chany_top_out, chany_bottom_out, chany_bottom_in, chany_top_in);
         end
`ifdef CB_CFG_PARITY_EN
         n_tests++; if (cfg_err !== m_err) begin n_fail++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, cfg_err, m_err); end
`endif
      end
      $display("[TB] random run of 400 cycles done");
   endtask

   initial begin
      pReset_n        = 1'b0;
      ccff_head       = 1'b0;
      ccff_shift_en   = 1'b0;
      chany_bottom_in = '0;
      chany_top_in    = '0;
      model_edge(0, 0, 0);
      test_reset();
      test_sel5();
      test_out_of_range();
      test_reload_gaps();
      test_mid_reset();
      test_short_frame();
`ifdef CB_CFG_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
